aux_island_player: RTL

// Downstream of the GMII receive stage on the aux path: drains the aux FIFO (25-bit words written by the receiver),

---
 rtl/aux_island_player_pkg.sv | 35 +++
 rtl/aux_island_player_ram.sv | 70 +++++++
 rtl/aux_island_player.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aux_island_player_pkg.sv
// Shared definitions for the aux data-island player.
// Provides the island body size, the bit layout of a 25-bit aux FIFO word,
// the play FSM state type and a helper that extracts the 9-bit island word.
package aux_island_player_pkg;

  localparam int unsigned ISLAND_WORDS = 32;
  localparam int unsigned WORD_AW      = $clog2(ISLAND_WORDS);

  // Aux FIFO word layout.
  localparam int unsigned AUX_W   = 25;
  localparam int unsigned TAG_MSB = 24;
  localparam int unsigned TAG_LSB = 9;
  localparam int unsigned HDR_BIT = 8;
  localparam int unsigned CH2_MSB = 7;
  localparam int unsigned CH2_LSB = 4;
  localparam int unsigned CH1_MSB = 3;
  localparam int unsigned CH1_LSB = 0;

  localparam int unsigned TAG_W  = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned DATA_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StLGuard,
    StData,
    StTGuard
  } play_state_e;

  // Island word = {ch0 header bit, ch2 nibble, ch1 nibble}.
  function automatic logic [DATA_W-1:0] aux_word_data(input logic [AUX_W-1:0] w);
    return {w[HDR_BIT], w[CH2_MSB:CH2_LSB], w[CH1_MSB:CH1_LSB]};
  endfunction

endpackage

// File: rtl/aux_island_player_ram.sv
// Two-bank ping-pong island buffer.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (clears tags and full flags)
//   i_wr_*              word write into bank i_wr_bank at i_wr_addr
//   i_tag_wr, i_tag     load the tag of bank i_wr_bank
//   i_set_full          mark bank i_wr_bank full
//   i_clr_full/bank     mark bank i_clr_bank empty
//   i_rd_*              registered read; o_rd_data valid the cycle after i_rd_en
//   o_bank_tag/full     per-bank tag and full flag
module aux_bank_ram
  import aux_island_player_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic                  i_wr_bank,
  input  logic [WORD_AW-1:0]    i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_tag_wr,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic                  i_set_full,
  input  logic                  i_clr_full,
  input  logic                  i_clr_bank,
  input  logic                  i_rd_en,
  input  logic                  i_rd_bank,
  input  logic [WORD_AW-1:0]    i_rd_addr,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic [1:0][TAG_W-1:0] o_bank_tag,
  output logic [1:0]            o_bank_full
);

  logic [DATA_W-1:0]     r_mem [0:2*ISLAND_WORDS-1];
  logic [DATA_W-1:0]     r_rd_data;
  logic [1:0][TAG_W-1:0] r_tag;
  logic [1:0]            r_full;

  // Storage array carries no reset; emptiness is tracked by the full flags.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
    end
  end

  // Fill only sets a bank that is not full and play only clears a full one,
  // so set and clear never target the same bank in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag  <= '0;
      r_full <= '0;
    end else begin
      if (i_tag_wr) begin
        r_tag[i_wr_bank] <= i_tag;
      end
      if (i_set_full) begin
        r_full[i_wr_bank] <= 1'b1;
      end
      if (i_clr_full) begin
        r_full[i_clr_bank] <= 1'b0;
      end
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_bank_tag  = r_tag;
  assign o_bank_full = r_full;

endmodule

// File: rtl/aux_island_player.sv
// Aux data-island player (pixel clock domain).
// Drains the aux FIFO into 32-word island bodies held in a two-bank ping-pong
// buffer and plays one complete island per timing-generator request as
// preamble / leading guard / data / trailing guard.
// Ports:
//   pclk, sys_rst     pixel clock, synchronous active-high reset
//   aux_dout          FIFO data: [24:9] tag, [8] hdr, [7:4] ch2, [3:0] ch1
//   aux_empty         FIFO empty
//   aux_rd_en         FIFO read strobe (data on aux_dout next cycle)
//   island_req        one-cycle request for one island
//   island_busy       high for the whole island
//   preamble, guard   control-period phase indicators
//   island_valid      high during the data words
//   island_data       current data word (0 outside data phase)
//   island_tag        tag of last accepted island
//   drop_cnt          saturating count of discarded partial islands
module aux_island_player
  import aux_island_player_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GUARD_LEN    = 2
) (
  input  logic              pclk,
  input  logic              sys_rst,
  input  logic [AUX_W-1:0]  aux_dout,
  input  logic              aux_empty,
  output logic              aux_rd_en,
  input  logic              island_req,
  output logic              island_busy,
  output logic              preamble,
  output logic              guard,
  output logic              island_valid,
  output logic [DATA_W-1:0] island_data,
  output logic [TAG_W-1:0]  island_tag,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] PreLast   = CntW'(PREAMBLE_LEN - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_LEN - 1);
  localparam logic [CntW-1:0] DataLast  = CntW'(ISLAND_WORDS - 1);
  localparam logic [WORD_AW-1:0] WordLast = WORD_AW'(ISLAND_WORDS - 1);

  // Shared buffer signals
  logic [1:0]            w_bank_full;
  logic [1:0][TAG_W-1:0] w_bank_tag;
  logic [DATA_W-1:0]     w_rd_data;

  // Fill side
  logic               r_fill_bank;
  logic [WORD_AW-1:0] r_fill_word;
  logic               r_rd_pend;
  logic [7:0]         r_drop_cnt;
  logic [TAG_W-1:0]   w_in_tag;
  logic               w_tag_miss;
  logic               w_restart;
  logic               w_last;
  logic               w_wr_en;
  logic [WORD_AW-1:0] w_wr_addr;

  // Play side
  play_state_e      r_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_play_bank;
  logic             r_busy;
  logic             r_pre;
  logic             r_guard;
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic             w_rd_en;
  logic [WORD_AW-1:0] w_rd_addr;
  logic             w_clr_full;

  // ---------------------------------------------------------------- fill
  assign w_in_tag   = aux_dout[TAG_MSB:TAG_LSB];
  assign w_tag_miss = (r_fill_word != '0) && (w_in_tag != w_bank_tag[r_fill_bank]);
  // A tag mismatch restarts the bank with the offending word as word 0.
  assign w_restart  = (r_fill_word == '0) || w_tag_miss;
  assign w_last     = !w_restart && (r_fill_word == WordLast);
  assign w_wr_en    = r_rd_pend && !sys_rst;
  assign w_wr_addr  = w_restart ? '0 : r_fill_word;

  // Only one read in flight, so a word never arrives for a bank that just filled.
  assign aux_rd_en = !sys_rst && !aux_empty && !r_rd_pend && !w_bank_full[r_fill_bank];

  always_ff @(posedge pclk) begin
    if (sys_rst) begin
      r_fill_bank <= 1'b0;
      r_fill_word <= '0;
      r_rd_pend   <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_rd_pend <= aux_rd_en;
      if (r_rd_pend) begin
        if (w_tag_miss && (r_drop_cnt != 8'hFF)) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
        if (w_last) begin
          r_fill_word <= '0;
          r_fill_bank <= ~r_fill_bank;
        end else if (w_restart) begin
          r_fill_word <= WORD_AW'(1);
        end else begin
          r_fill_word <= r_fill_word + WORD_AW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- play
  // RAM address runs one word ahead so read data lines up with island_valid.
  assign w_rd_en    = ((r_state == StLGuard) && (r_cnt == GuardLast)) || (r_state == StData);
  assign w_rd_addr  = (r_state == StData) ? (r_cnt[WORD_AW-1:0] + WORD_AW'(1)) : '0;
  assign w_clr_full = (r_state == StTGuard) && (r_cnt == GuardLast);

  always_ff @(posedge pclk) begin
    if (sys_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_play_bank <= 1'b0;
      r_busy      <= 1'b0;
      r_pre       <= 1'b0;
      r_guard     <= 1'b0;
      r_valid     <= 1'b0;
      r_tag       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Registered full flag: a bank filling this very cycle is not yet eligible.
          if (island_req && w_bank_full[r_play_bank]) begin
            r_state <= StPre;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_pre   <= 1'b1;
            r_tag   <= w_bank_tag[r_play_bank];
          end
        end
        StPre: begin
          if (r_cnt == PreLast) begin
            r_state <= StLGuard;
            r_cnt   <= '0;
            r_pre   <= 1'b0;
            r_guard <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StLGuard: begin
          if (r_cnt == GuardLast) begin
            r_state <= StData;
            r_cnt   <= '0;
            r_guard <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == DataLast) begin
            r_state <= StTGuard;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_guard <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StTGuard: begin
          if (r_cnt == GuardLast) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_guard     <= 1'b0;
            r_busy      <= 1'b0;
            r_play_bank <= ~r_play_bank;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  aux_bank_ram u_ram (
    .i_clk       (pclk),
    .i_rst       (sys_rst),
    .i_wr_en     (w_wr_en),
    .i_wr_bank   (r_fill_bank),
    .i_wr_addr   (w_wr_addr),
    .i_wr_data   (aux_word_data(aux_dout)),
    .i_tag_wr    (w_wr_en && w_restart),
    .i_tag       (w_in_tag),
    .i_set_full  (w_wr_en && w_last),
    .i_clr_full  (w_clr_full),
    .i_clr_bank  (r_play_bank),
    .i_rd_en     (w_rd_en),
    .i_rd_bank   (r_play_bank),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data   (w_rd_data),
    .o_bank_tag  (w_bank_tag),
    .o_bank_full (w_bank_full)
  );

  assign island_busy  = r_busy;
  assign preamble     = r_pre;
  assign guard        = r_guard;
  assign island_valid = r_valid;
  assign island_data  = r_valid ? w_rd_data : '0;
  assign island_tag   = r_tag;
  assign drop_cnt     = r_drop_cnt;

endmodule
